// File: rtl/top_bus_pkg.sv
// rtl/top_bus_pkg.sv - shared bus encodings, field widths and arbiter state type
package top_bus_pkg;

    localparam logic [1:0] TRANS_IDLE   = 2'd0;
    localparam logic [1:0] TRANS_BUSY   = 2'd1;
    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/top_bus_arb_if.sv
// rtl/top_bus_arb_if.sv - requester-side and target-side bus signals of the arbiter
interface top_bus_arb_if
    import top_bus_pkg::*;
#(
    parameter int num_p = 2
);

    logic [num_p*2-1:0]      req_trans_i;
    logic [num_p*ADDR_W-1:0] req_addr_i;
    logic [num_p-1:0]        req_write_i;
    logic [num_p*DATA_W-1:0] req_wdata_i;
    logic [num_p-1:0]        req_ready_o;
    logic [num_p-1:0]        req_resp_o;
    logic [DATA_W-1:0]       req_rdata_o;

    logic [1:0]              bus_trans_o;
    logic [ADDR_W-1:0]       bus_addr_o;
    logic                    bus_write_o;
    logic [DATA_W-1:0]       bus_wdata_o;
    logic                    bus_ready_i;
    logic                    bus_resp_i;
    logic [DATA_W-1:0]       bus_rdata_i;

    modport slave (
        input  req_trans_i, req_addr_i, req_write_i, req_wdata_i,
        output req_ready_o, req_resp_o, req_rdata_o,
        output bus_trans_o, bus_addr_o, bus_write_o, bus_wdata_o,
        input  bus_ready_i, bus_resp_i, bus_rdata_i
    );

    modport master (
        output req_trans_i, req_addr_i, req_write_i, req_wdata_i,
        input  req_ready_o, req_resp_o, req_rdata_o,
        input  bus_trans_o, bus_addr_o, bus_write_o, bus_wdata_o,
        output bus_ready_i, bus_resp_i, bus_rdata_i
    );

endinterface

// File: rtl/top_rr_pick.sv
// rtl/top_rr_pick.sv - combinational round-robin picker: first requester after last, wrapping
module top_rr_pick #(
    parameter int num_p = 2,
    parameter int idx_w = (num_p > 1) ? $clog2(num_p) : 1
) (
    input  logic [num_p-1:0] req,
    input  logic [idx_w-1:0] last,
    output logic [num_p-1:0] gnt,
    output logic [idx_w-1:0] idx
);

    always_comb begin
        int               cand;
        logic [idx_w-1:0] c;
        logic             found;
        cand  = 0;
        c     = '0;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        // Visit last+1, last+2, ... so the previous winner is checked last.
        for (int i = 1; i <= num_p; i++) begin
            cand = (int'(last) + i) % num_p;
            c    = idx_w'(cand);
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = c;
            end
        end
    end

endmodule

// File: rtl/top_bus_arb.sv
// rtl/top_bus_arb.sv - round-robin bus arbiter, one transfer per grant; watchdog under TOP_BUS_ARB_TOUT_EN
module top_bus_arb
    import top_bus_pkg::*;
#(
    parameter int num_p  = 2,
    parameter int tout_p = 255
) (
    input  logic             main_clk_i,
    input  logic             main_rst_i,
    top_bus_arb_if.slave     bus,
    output logic [num_p-1:0] grant_o,
    output logic             tout_o
);

    localparam int IDX_W = $clog2(num_p);

    arb_state_t       state_q, state_d;
    logic [num_p-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [num_p-1:0] req_vec;
    logic [num_p-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             busy;
    logic             tout_hit;
    logic             done;

    always_comb begin
        req_vec = '0;
        for (int k = 0; k < num_p; k++) begin
            req_vec[k] = (bus.req_trans_i[2*k +: 2] != TRANS_IDLE);
        end
    end

    top_rr_pick #(
        .num_p (num_p),
        .idx_w (IDX_W)
    ) u_pick (
        .req  (req_vec),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    assign busy = (state_q == ST_BUSY);

`ifdef TOP_BUS_ARB_TOUT_EN
    logic [15:0] cnt_q;

    // Held at zero outside BUSY, so every transfer starts counting from zero.
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i || !busy) begin
            cnt_q <= '0;
        end else if (!bus.bus_ready_i) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign tout_hit = busy && !bus.bus_ready_i && (cnt_q == 16'(tout_p - 1));
`else
    assign tout_hit = 1'b0;
`endif

    assign tout_o  = tout_hit;
    assign done    = busy && (bus.bus_ready_i || tout_hit);
    assign grant_o = grant_q;

    always_comb begin
        bus.bus_trans_o = TRANS_IDLE;
        bus.bus_addr_o  = '0;
        bus.bus_write_o = 1'b0;
        bus.bus_wdata_o = '0;
        for (int k = 0; k < num_p; k++) begin
            if (busy && grant_q[k]) begin
                bus.bus_trans_o = bus.req_trans_i[2*k +: 2];
                bus.bus_addr_o  = bus.req_addr_i[ADDR_W*k +: ADDR_W];
                bus.bus_write_o = bus.req_write_i[k];
                bus.bus_wdata_o = bus.req_wdata_i[DATA_W*k +: DATA_W];
            end
        end
    end

    // An abort reports an error with zero data; a late target response is never routed.
    assign bus.req_ready_o = done ? grant_q : '0;
    assign bus.req_resp_o  = (done && (bus.bus_resp_i || tout_hit)) ? grant_q : '0;
    assign bus.req_rdata_o = (busy && bus.bus_ready_i) ? bus.bus_rdata_i : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (state_q == ST_IDLE) begin
            if (|req_vec) begin
                state_d = ST_BUSY;
                grant_d = pick_gnt;
                idx_d   = pick_idx;
            end
        end else begin
            if (done) begin
                state_d = ST_IDLE;
                grant_d = '0;
                last_d  = idx_q;
            end
        end
    end

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IDX_W'(num_p - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_top_bus_arb.sv
// tb/tb_top_bus_arb.sv - directed and randomized checks of top_bus_arb against a behavioural model
module tb_top_bus_arb;
    import top_bus_pkg::*;

    localparam int NP   = 4;
    localparam int TOUT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    top_bus_arb_if #(.num_p(NP)) ifc ();
    logic [NP-1:0] grant;
    logic          tout;

    top_bus_arb #(.num_p(NP), .tout_p(TOUT)) dut (
        .main_clk_i (clk),
        .main_rst_i (rst),
        .bus        (ifc),
        .grant_o    (grant),
        .tout_o     (tout)
    );

    logic [1:0]  t_trans [NP];
    logic [31:0] t_addr  [NP];
    logic        t_write [NP];
    logic [31:0] t_wdata [NP];
    logic        b_ready;
    logic        b_resp;
    logic [31:0] b_rdata;

    always_comb begin
        for (int k = 0; k < NP; k++) begin
            ifc.req_trans_i[2*k +: 2]  = t_trans[k];
            ifc.req_addr_i[32*k +: 32] = t_addr[k];
            ifc.req_write_i[k]         = t_write[k];
            ifc.req_wdata_i[32*k +: 32] = t_wdata[k];
        end
    end
    assign ifc.bus_ready_i = b_ready;
    assign ifc.bus_resp_i  = b_resp;
    assign ifc.bus_rdata_i = b_rdata;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        for (int k = 0; k < NP; k++) begin
            t_trans[k] = 2'd0;
            t_addr[k]  = 32'd0;
            t_write[k] = 1'b0;
            t_wdata[k] = 32'd0;
        end
    endtask

    // Model: owner index (-1 when nobody holds the bus), last winner, cycles spent owning.
    logic          run = 1'b0;
    int            m_own = -1;
    int            m_last = NP - 1;
    int            m_age = 0;
    logic [NP-1:0] rdy_seen = '0;

    always @(negedge clk) begin : cmp
        bit          busy, hit, done;
        int          c;
        logic [31:0] e_grant, e_resp;
        if (run) begin
            busy = (m_own >= 0);
            hit  = 1'b0;
`ifdef TOP_BUS_ARB_TOUT_EN
            hit  = busy && !b_ready && (m_age == TOUT);
`endif
            done    = busy && (b_ready || hit);
            e_grant = busy ? (32'd1 << m_own) : 32'd0;
            e_resp  = (done && (hit || b_resp)) ? e_grant : 32'd0;
            chk("grant",     32'(grant), e_grant);
            chk("bus_trans", 32'(ifc.bus_trans_o), busy ? 32'(t_trans[m_own]) : 32'd0);
            chk("bus_addr",  ifc.bus_addr_o, busy ? t_addr[m_own] : 32'd0);
            chk("bus_write", 32'(ifc.bus_write_o), busy ? 32'(t_write[m_own]) : 32'd0);
            chk("bus_wdata", ifc.bus_wdata_o, busy ? t_wdata[m_own] : 32'd0);
            chk("req_ready", 32'(ifc.req_ready_o), done ? e_grant : 32'd0);
            chk("req_resp",  32'(ifc.req_resp_o), e_resp);
            chk("req_rdata", ifc.req_rdata_o, (busy && b_ready) ? b_rdata : 32'd0);
            chk("tout",      32'(tout), 32'(hit));
            rdy_seen = ifc.req_ready_o;
            if (rst) begin
                m_own = -1; m_last = NP - 1; m_age = 0;
            end else if (busy) begin
                if (done) begin
                    m_last = m_own; m_own = -1;
                end else begin
                    m_age++;
                end
            end else begin
                for (int i = 1; i <= NP; i++) begin
                    c = (m_last + i) % NP;
                    if (t_trans[c] != 2'd0) begin
                        m_own = c; m_age = 1;
                        break;
                    end
                end
            end
        end
    end

    logic act [NP];

    initial begin
        rst = 1'b1;
        clr_req();
        b_ready = 1'b0; b_resp = 1'b0; b_rdata = 32'd0;
        for (int k = 0; k < NP; k++) act[k] = 1'b0;
        cyc(); cyc(); run = 1'b1;
        #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_trans", 32'(ifc.bus_trans_o), 32'd0);
        chk("rst_ready", 32'(ifc.req_ready_o), 32'd0);
        cyc(); rst = 1'b0;

        // Single read by requester 2
        cyc(); t_trans[2] = TRANS_NONSEQ; t_addr[2] = 32'h10;
        #2; chk("sr_pre_grant", 32'(grant), 32'd0);
        cyc(); #2;
        chk("sr_grant", 32'(grant), 32'h4);
        chk("sr_addr", ifc.bus_addr_o, 32'h10);
        cyc();
        cyc(); b_ready = 1'b1; b_rdata = 32'hCAFE0001;
        #2;
        chk("sr_ready", 32'(ifc.req_ready_o), 32'h4);
        chk("sr_rdata", ifc.req_rdata_o, 32'hCAFE0001);
        cyc(); b_ready = 1'b0; b_rdata = 32'd0; t_trans[2] = 2'd0;
        #2; chk("sr_release", 32'(grant), 32'd0);

        // Fairness with all requesters busy and an always-ready target
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; b_ready = 1'b1;
        for (int k = 0; k < NP; k++) t_trans[k] = TRANS_NONSEQ;
        for (int j = 0; j < 9; j++) begin
            cyc(); #2;
            if (j % 2 == 0) chk("fair_grant", 32'(grant), 32'd1 << ((j / 2) % NP));
            else            chk("fair_gap", 32'(grant), 32'd0);
        end
        cyc(); clr_req(); b_ready = 1'b0;

        // Isolation between requester 1 and a concurrent write from 3, then error response
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        t_trans[1] = TRANS_NONSEQ; t_write[1] = 1'b1; t_wdata[1] = 32'h1111;
        t_trans[3] = TRANS_NONSEQ; t_write[3] = 1'b1; t_wdata[3] = 32'hDEAD;
        cyc(); #2;
        chk("iso_grant", 32'(grant), 32'h2);
        chk("iso_wdata", ifc.bus_wdata_o, 32'h1111);
        chk("iso_rdy3", 32'(ifc.req_ready_o[3]), 32'd0);
        cyc(); #2;
        chk("iso_wdata_hold", ifc.bus_wdata_o, 32'h1111);
        cyc(); b_ready = 1'b1;
        #2; chk("iso_done", 32'(ifc.req_ready_o), 32'h2);
        cyc(); b_ready = 1'b0; t_trans[1] = 2'd0;
        #2;
        chk("iso_gap", 32'(grant), 32'd0);
        chk("iso_rdy3_gap", 32'(ifc.req_ready_o[3]), 32'd0);
        cyc(); #2;
        chk("iso_grant3", 32'(grant), 32'h8);
        chk("iso_wdata3", ifc.bus_wdata_o, 32'hDEAD);
        cyc(); b_ready = 1'b1; b_resp = 1'b1;
        #2;
        chk("err_resp", 32'(ifc.req_resp_o), 32'h8);
        chk("err_ready", 32'(ifc.req_ready_o), 32'h8);
        cyc(); b_ready = 1'b0; b_resp = 1'b0; t_trans[3] = 2'd0;
        t_trans[2] = TRANS_NONSEQ; t_addr[2] = 32'h20;

        // Reset while requester 2 is mid-transfer
        cyc(); t_trans[0] = TRANS_NONSEQ;
        #2; chk("rm_grant", 32'(grant), 32'h4);
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        #2;
        chk("rm_grant_clr", 32'(grant), 32'd0);
        chk("rm_trans", 32'(ifc.bus_trans_o), 32'd0);
        chk("rm_ready", 32'(ifc.req_ready_o), 32'd0);
        cyc(); #2; chk("rm_next", 32'(grant), 32'h1);
        cyc(); b_ready = 1'b1;
        cyc(); b_ready = 1'b0; clr_req();

        // Target that never answers
        cyc(); t_trans[1] = TRANS_NONSEQ; t_addr[1] = 32'h40; b_rdata = 32'h55AA55AA;
        for (int b = 1; b <= TOUT; b++) begin
            cyc(); #2;
`ifdef TOP_BUS_ARB_TOUT_EN
            if (b < TOUT) begin
                chk("wd_quiet", 32'(tout), 32'd0);
                chk("wd_wait", 32'(ifc.req_ready_o), 32'd0);
            end else begin
                chk("wd_ready", 32'(ifc.req_ready_o), 32'h2);
                chk("wd_resp", 32'(ifc.req_resp_o), 32'h2);
                chk("wd_rdata", ifc.req_rdata_o, 32'd0);
                chk("wd_pulse", 32'(tout), 32'd1);
            end
`else
            chk("hang_grant", 32'(grant), 32'h2);
            chk("hang_tout", 32'(tout), 32'd0);
`endif
        end
`ifdef TOP_BUS_ARB_TOUT_EN
        cyc(); t_trans[1] = 2'd0; b_ready = 1'b1;
        #2;
        chk("wd_late", 32'(ifc.req_ready_o), 32'd0);
        chk("wd_idle", 32'(grant), 32'd0);
        chk("wd_pulse_end", 32'(tout), 32'd0);
`else
        cyc(); b_ready = 1'b1;
        #2;
        chk("hang_done", 32'(ifc.req_ready_o), 32'h2);
        chk("hang_rdata", ifc.req_rdata_o, 32'h55AA55AA);
`endif
        cyc(); b_ready = 1'b0; b_rdata = 32'd0; clr_req();

        // Randomized traffic, protocol-following requesters and a random target
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst = ($urandom_range(0, 499) == 0);
            for (int k = 0; k < NP; k++) begin
                if (act[k] && rdy_seen[k]) act[k] = 1'b0;
                if (!act[k]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        act[k]     = 1'b1;
                        t_trans[k] = 2'($urandom_range(1, 3));
                        t_addr[k]  = $urandom;
                        t_write[k] = 1'($urandom_range(0, 1));
                        t_wdata[k] = $urandom;
                    end else begin
                        t_trans[k] = 2'd0;
                    end
                end
            end
            b_ready = ($urandom_range(0, 3) == 0);
            b_resp  = ($urandom_range(0, 4) == 0);
            b_rdata = $urandom;
        end
        cyc(); cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
